// File: rtl/axi_trans_dependency_gate_pkg.sv
// Shared constants for the address-channel dependency gate: FSM encoding,
// default widths agreed with the transaction controller, and the admission rule.
package axi_trans_dependency_gate_pkg;

    localparam int DEP_NUM_SLAVES_WIDTH = 2;
    localparam int DEP_MASTERID_WIDTH   = 4;
    localparam int DEP_OPEN_TRANS_MAX   = 3;
    localparam int DEP_OPEN_TRANS_WIDTH = 2;
    localparam int DEP_STALL_LIMIT      = 255;
    localparam int DEP_STALL_WIDTH      = 8;

    localparam logic [1:0] DEP_ST_IDLE    = 2'd0;
    localparam logic [1:0] DEP_ST_CHECK   = 2'd1;
    localparam logic [1:0] DEP_ST_BLOCKED = 2'd2;
    localparam logic [1:0] DEP_ST_ARB     = 2'd3;

    // A known thread may only grow on its own slave and below its cap; a new ID needs a free slot.
    function automatic logic dep_pass(
        input logic thread_valid,
        input logic thread_avail,
        input logic same_slave,
        input logic below_max
    );
        logic pass_s;
        if (thread_valid) begin
            pass_s = same_slave & below_max;
        end else begin
            pass_s = thread_avail;
        end
        return pass_s;
    endfunction

endpackage

// File: rtl/axi_dep_stall_timer.sv
// Saturating blocked-cycle counter with a sticky timeout flag.
// Exists only when AXI_DEP_STALL_TIMEOUT_EN is defined.
`ifdef AXI_DEP_STALL_TIMEOUT_EN
module axi_dep_stall_timer #(
    parameter int STALL_LIMIT = 255,
    parameter int STALL_WIDTH = 8
) (
    input  logic sysClk,
    input  logic sysReset,
    input  logic blocked_i,
    output logic stall_err_o
);

    localparam logic [STALL_WIDTH-1:0] CNT_MAX   = {STALL_WIDTH{1'b1}};
    localparam logic [STALL_WIDTH-1:0] CNT_LIMIT = STALL_WIDTH'(STALL_LIMIT);

    logic [STALL_WIDTH-1:0] cnt_q;
    logic [STALL_WIDTH-1:0] cnt_d;
    logic                   err_q;
    logic                   err_d;

    // Counter sits at zero outside BLOCKED, so every entry starts a fresh count.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (!blocked_i) begin
            cnt_d = {STALL_WIDTH{1'b0}};
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + {{(STALL_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
        if (cnt_d == CNT_LIMIT) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // Counter and sticky flag state.
    always_ff @(posedge sysClk or negedge sysReset) begin
        if (!sysReset) begin
            cnt_q <= {STALL_WIDTH{1'b0}};
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign stall_err_o = err_q;

endmodule
`endif

// File: rtl/axi_trans_dependency_gate.sv
// Single-entry AW/AR admission gate ahead of the target-mux arbiter.
// Optional stall timeout (depStallErr) enabled by AXI_DEP_STALL_TIMEOUT_EN.
module axi_trans_dependency_gate
    import axi_trans_dependency_gate_pkg::*;
#(
    parameter int NUM_SLAVES_WIDTH = DEP_NUM_SLAVES_WIDTH,
    parameter int MASTERID_WIDTH   = DEP_MASTERID_WIDTH,
    parameter int OPEN_TRANS_MAX   = DEP_OPEN_TRANS_MAX,
    parameter int OPEN_TRANS_WIDTH = DEP_OPEN_TRANS_WIDTH,
    parameter int STALL_LIMIT      = DEP_STALL_LIMIT,
    parameter int STALL_WIDTH      = DEP_STALL_WIDTH
) (
    input  logic                        sysClk,
    input  logic                        sysReset,
    input  logic                        reqValid,
    input  logic [MASTERID_WIDTH-1:0]   reqID,
    input  logic [NUM_SLAVES_WIDTH-1:0] reqSlaveID,
    output logic                        reqReady,
    output logic [MASTERID_WIDTH-1:0]   currTransID,
    output logic [NUM_SLAVES_WIDTH-1:0] currTransSlaveID,
    input  logic                        threadAvail,
    input  logic                        threadValid,
    input  logic [OPEN_TRANS_WIDTH-1:0] threadCount,
    input  logic [NUM_SLAVES_WIDTH-1:0] threadSlaveID,
    output logic                        arbReq,
    output logic [NUM_SLAVES_WIDTH-1:0] arbSlaveID,
    input  logic                        arbGrant,
    output logic                        openTransInc
`ifdef AXI_DEP_STALL_TIMEOUT_EN
    ,
    output logic                        depStallErr
`endif
);

    localparam logic [OPEN_TRANS_WIDTH-1:0] CNT_CAP = OPEN_TRANS_WIDTH'(OPEN_TRANS_MAX);

    logic [1:0]                  state_q;
    logic [1:0]                  state_d;
    logic [MASTERID_WIDTH-1:0]   id_q;
    logic [MASTERID_WIDTH-1:0]   id_d;
    logic [NUM_SLAVES_WIDTH-1:0] slave_q;
    logic [NUM_SLAVES_WIDTH-1:0] slave_d;
    logic                        pass_s;

    assign pass_s = dep_pass(threadValid, threadAvail,
                             threadSlaveID == slave_q, threadCount < CNT_CAP);

    // Next-state and capture logic; the held request only changes on acceptance.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        slave_d = slave_q;
        case (state_q)
            DEP_ST_IDLE: begin
                if (reqValid) begin
                    id_d    = reqID;
                    slave_d = reqSlaveID;
                    state_d = DEP_ST_CHECK;
                end else begin
                    state_d = DEP_ST_IDLE;
                end
            end
            DEP_ST_CHECK: begin
                if (pass_s) begin
                    state_d = DEP_ST_ARB;
                end else begin
                    state_d = DEP_ST_BLOCKED;
                end
            end
            DEP_ST_BLOCKED: begin
                if (pass_s) begin
                    state_d = DEP_ST_ARB;
                end else begin
                    state_d = DEP_ST_BLOCKED;
                end
            end
            DEP_ST_ARB: begin
                if (arbGrant) begin
                    state_d = DEP_ST_IDLE;
                end else begin
                    state_d = DEP_ST_ARB;
                end
            end
            default: begin
                state_d = DEP_ST_IDLE;
            end
        endcase
    end

    // FSM and holding registers; reset drops any in-flight request.
    always_ff @(posedge sysClk or negedge sysReset) begin
        if (!sysReset) begin
            state_q <= DEP_ST_IDLE;
            id_q    <= {MASTERID_WIDTH{1'b0}};
            slave_q <= {NUM_SLAVES_WIDTH{1'b0}};
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            slave_q <= slave_d;
        end
    end

    assign reqReady         = (state_q == DEP_ST_IDLE);
    assign arbReq           = (state_q == DEP_ST_ARB);
    assign arbSlaveID       = slave_q;
    assign currTransID      = id_q;
    assign currTransSlaveID = slave_q;
    // The increment must coincide with the grant cycle, so it follows arbGrant directly.
    assign openTransInc     = (state_q == DEP_ST_ARB) & arbGrant;

`ifdef AXI_DEP_STALL_TIMEOUT_EN
    axi_dep_stall_timer #(
        .STALL_LIMIT (STALL_LIMIT),
        .STALL_WIDTH (STALL_WIDTH)
    ) u_stall_timer (
        .sysClk      (sysClk),
        .sysReset    (sysReset),
        .blocked_i   (state_q == DEP_ST_BLOCKED),
        .stall_err_o (depStallErr)
    );
`endif

endmodule

// File: tb/tb_axi_trans_dependency_gate.sv
// Scoreboard bench for axi_trans_dependency_gate: directed requests push the
// expected grant into a queue, a negedge monitor pops it on each openTransInc.
module tb_axi_trans_dependency_gate;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] slave;
    } exp_t;

    logic       sysClk = 1'b0;
    logic       sysReset;
    logic       reqValid;
    logic [3:0] reqID;
    logic [1:0] reqSlaveID;
    logic       reqReady;
    logic [3:0] currTransID;
    logic [1:0] currTransSlaveID;
    logic       threadAvail;
    logic       threadValid;
    logic [1:0] threadCount;
    logic [1:0] threadSlaveID;
    logic       arbReq;
    logic [1:0] arbSlaveID;
    logic       arbGrant;
    logic       openTransInc;
`ifdef AXI_DEP_STALL_TIMEOUT_EN
    logic       depStallErr;
`endif

    int   n_vec  = 0;
    int   n_fail = 0;
    exp_t exp_q[$];

    always #5 sysClk = ~sysClk;

`ifdef AXI_DEP_STALL_TIMEOUT_EN
    axi_trans_dependency_gate #(.STALL_LIMIT(4)) dut (
`else
    axi_trans_dependency_gate dut (
`endif
        .sysClk           (sysClk),
        .sysReset         (sysReset),
        .reqValid         (reqValid),
        .reqID            (reqID),
        .reqSlaveID       (reqSlaveID),
        .reqReady         (reqReady),
        .currTransID      (currTransID),
        .currTransSlaveID (currTransSlaveID),
        .threadAvail      (threadAvail),
        .threadValid      (threadValid),
        .threadCount      (threadCount),
        .threadSlaveID    (threadSlaveID),
        .arbReq           (arbReq),
        .arbSlaveID       (arbSlaveID),
        .arbGrant         (arbGrant),
        .openTransInc     (openTransInc)
`ifdef AXI_DEP_STALL_TIMEOUT_EN
        ,
        .depStallErr      (depStallErr)
`endif
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Advance to just after the next rising edge; inputs are changed here.
    task automatic tick();
        @(posedge sysClk);
        #1;
    endtask

    // Let outputs settle inside the current cycle before checking.
    task automatic settle();
        #2;
    endtask

    task automatic issue(input logic [3:0] id, input logic [1:0] sl, input logic expect_grant);
        reqValid   = 1'b1;
        reqID      = id;
        reqSlaveID = sl;
        if (expect_grant) exp_q.push_back('{id: id, slave: sl});
        tick();
        reqValid   = 1'b0;
    endtask

    // Monitor: every increment pulse must match the oldest outstanding request.
    always @(negedge sysClk) begin
        if (sysReset === 1'b1 && openTransInc === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_inc", 8'd1, 8'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("inc_arbSlaveID", {6'd0, arbSlaveID}, {6'd0, e.slave});
                check("inc_currTransID", {4'd0, currTransID}, {4'd0, e.id});
                check("inc_arbReq", {7'd0, arbReq}, 8'd1);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        sysReset = 1'b0; reqValid = 1'b0; reqID = 4'h0; reqSlaveID = 2'd0;
        threadAvail = 1'b0; threadValid = 1'b0; threadCount = 2'd0;
        threadSlaveID = 2'd0; arbGrant = 1'b0;
        tick(); settle();
        check("rst_reqReady", {7'd0, reqReady}, 8'd1);
        check("rst_arbReq", {7'd0, arbReq}, 8'd0);
        check("rst_openTransInc", {7'd0, openTransInc}, 8'd0);
        check("rst_currTransID", {4'd0, currTransID}, 8'd0);
        check("rst_currTransSlaveID", {6'd0, currTransSlaveID}, 8'd0);
`ifdef AXI_DEP_STALL_TIMEOUT_EN
        check("rst_depStallErr", {7'd0, depStallErr}, 8'd0);
`endif
        tick();
        sysReset = 1'b1;
        tick();

        // New ID, free slot, immediate grant: CHECK, ARB+inc, IDLE.
        threadAvail = 1'b1; arbGrant = 1'b1;
        issue(4'h5, 2'd2, 1'b1);
        settle();
        check("t1_check_reqReady", {7'd0, reqReady}, 8'd0);
        check("t1_check_arbReq", {7'd0, arbReq}, 8'd0);
        check("t1_currTransID", {4'd0, currTransID}, 8'h05);
        tick(); settle();
        check("t1_arbReq", {7'd0, arbReq}, 8'd1);
        check("t1_inc", {7'd0, openTransInc}, 8'd1);
        tick(); settle();
        check("t1_reqReady_back", {7'd0, reqReady}, 8'd1);
        check("t1_arbReq_drop", {7'd0, arbReq}, 8'd0);

        // Same ID bound to another slave: blocked until the thread is gone.
        threadValid = 1'b1; threadSlaveID = 2'd2; threadCount = 2'd1;
        issue(4'h5, 2'd1, 1'b1);
        settle();
        check("t2_check_arbReq", {7'd0, arbReq}, 8'd0);
        tick();
        threadValid = 1'b0;
        settle();
        check("t2_blocked_arbReq", {7'd0, arbReq}, 8'd0);
        check("t2_blocked_reqReady", {7'd0, reqReady}, 8'd0);
        tick(); settle();
        check("t2_arbReq", {7'd0, arbReq}, 8'd1);
        check("t2_arbSlaveID", {6'd0, arbSlaveID}, 8'd1);
        tick();

        // Same slave, count at the cap: pass the cycle after it drops.
        threadValid = 1'b1; threadSlaveID = 2'd3; threadCount = 2'd3;
        issue(4'h7, 2'd3, 1'b1);
        settle();
        check("t3_check_arbReq", {7'd0, arbReq}, 8'd0);
        tick(); settle();
        check("t3_blocked_arbReq", {7'd0, arbReq}, 8'd0);
        tick();
        threadCount = 2'd2;
        settle();
        check("t3_drop_arbReq", {7'd0, arbReq}, 8'd0);
        tick(); settle();
        check("t3_arbReq", {7'd0, arbReq}, 8'd1);
        tick(); settle();
        check("t3_idle_inc", {7'd0, openTransInc}, 8'd0);
        check("t3_reqReady", {7'd0, reqReady}, 8'd1);

        // No thread slot for 10 cycles.
        threadValid = 1'b0; threadAvail = 1'b0;
        issue(4'h9, 2'd0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            settle();
            check("t4_wait_reqReady", {7'd0, reqReady}, 8'd0);
            check("t4_wait_arbReq", {7'd0, arbReq}, 8'd0);
            tick();
        end
        threadAvail = 1'b1;
        settle();
        check("t4_rise_arbReq", {7'd0, arbReq}, 8'd0);
`ifdef AXI_DEP_STALL_TIMEOUT_EN
        check("t4_depStallErr", {7'd0, depStallErr}, 8'd1);
`endif
        tick(); settle();
        check("t4_arbReq", {7'd0, arbReq}, 8'd1);
        tick(); settle();
        check("t4_reqReady", {7'd0, reqReady}, 8'd1);
`ifdef AXI_DEP_STALL_TIMEOUT_EN
        check("t4_depStallErr_sticky", {7'd0, depStallErr}, 8'd1);
`endif

        // Grant withheld for 5 ARB cycles, then a single pulse.
        arbGrant = 1'b0;
        issue(4'hA, 2'd1, 1'b1);
        tick();
        for (int i = 0; i < 5; i++) begin
            settle();
            check("t5_hold_arbReq", {7'd0, arbReq}, 8'd1);
            check("t5_hold_arbSlaveID", {6'd0, arbSlaveID}, 8'd1);
            check("t5_hold_inc", {7'd0, openTransInc}, 8'd0);
            tick();
        end
        arbGrant = 1'b1;
        settle();
        check("t5_grant_arbReq", {7'd0, arbReq}, 8'd1);
        check("t5_grant_inc", {7'd0, openTransInc}, 8'd1);
        tick();
        arbGrant = 1'b0;
        settle();
        check("t5_reqReady", {7'd0, reqReady}, 8'd1);

        // Reset during ARB discards the request without an increment.
        issue(4'hC, 2'd3, 1'b0);
        tick(); settle();
        check("t6_arbReq", {7'd0, arbReq}, 8'd1);
        sysReset = 1'b0;
        arbGrant = 1'b1;
        settle();
        check("t6_rst_reqReady", {7'd0, reqReady}, 8'd1);
        check("t6_rst_arbReq", {7'd0, arbReq}, 8'd0);
        check("t6_rst_inc", {7'd0, openTransInc}, 8'd0);
        check("t6_rst_currTransID", {4'd0, currTransID}, 8'd0);
        tick();
        sysReset = 1'b1;
        arbGrant = 1'b0;
        tick(); settle();
        check("t6_post_arbReq", {7'd0, arbReq}, 8'd0);
        check("t6_post_reqReady", {7'd0, reqReady}, 8'd1);
        tick();

        check("scoreboard_empty", 8'(exp_q.size()), 8'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
